// File: rtl/dual_helix_pkg.sv
// Shared types for the dual_helix_soc peripheral domain: APB request/response
// structs, address/data words, base addresses, and the config sequencer's
// state enum and table-entry record.
package dual_helix_pkg;

  typedef logic [31:0] dhs_addr_t;
  typedef logic [31:0] dhs_data_t;

  localparam dhs_addr_t RAM_BASE  = 32'h2000_0000;
  localparam dhs_addr_t UART_BASE = 32'h4000_0000;

  typedef struct packed {
    dhs_addr_t  paddr;
    logic       psel;
    logic       penable;
    logic       pwrite;
    dhs_data_t  pwdata;
    logic [3:0] pstrb;
  } dhs_apb_req_t;

  typedef struct packed {
    dhs_data_t prdata;
    logic      pready;
    logic      pslverr;
  } dhs_apb_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_SETUP,
    ST_W_ACCESS,
    ST_R_SETUP,
    ST_R_ACCESS,
    ST_DONE
  } apb_cfg_seq_state_e;

  typedef struct packed {
    dhs_addr_t addr;
    dhs_data_t data;
    logic      verify;
  } apb_cfg_entry_t;

endpackage

// File: rtl/apb_cfg_seq_timeout.sv
// Purpose: loadable down-counter bounding how long an APB ACCESS phase may wait.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th enabled cycle after load.
// Backpressure: none; the owner reloads it in every SETUP phase.
// Ports: clk, rst_n (async active-low), load (SETUP phase), count_en (ACCESS phase),
//        expired (ACCESS has lasted TIMEOUT_CYCLES cycles, including this one).
module apb_cfg_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Loaded with T-1 so that the T-th ACCESS cycle sees zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(TIMEOUT_CYCLES - 1);
    end else if (count_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = count_en && (cnt_q == '0);

endmodule

// File: rtl/apb_cfg_sequencer.sv
// Purpose: boot-time APB master writing a NUM_ENTRIES table, with optional readback.
// Latency: start edge -> psel next cycle; 2 cycles per zero-wait transfer; done one cycle after last ACCESS.
// Backpressure: waits on pready per transfer, bounded by TIMEOUT_CYCLES; start ignored while busy.
// Ports: clk_i/arst_ni; start_i/abort_i control; cfg_{addr,data,verify}_i table;
//        apb_req_o/apb_resp_i APB master; busy_o, done_o, err_o, err_idx_o, err_cnt_o status.
// Build option: define APB_CFG_SEQ_VERIFY_EN to add the readback-compare read phases.
module apb_cfg_sequencer
  import dual_helix_pkg::*;
#(
  parameter  int NUM_ENTRIES    = 4,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int IW             = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int CW             = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  dhs_addr_t [NUM_ENTRIES-1:0]  cfg_addr_i,
  input  dhs_data_t [NUM_ENTRIES-1:0]  cfg_data_i,
  input  logic      [NUM_ENTRIES-1:0]  cfg_verify_i,
  output dhs_apb_req_t                 apb_req_o,
  input  dhs_apb_resp_t                apb_resp_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [IW-1:0]                err_idx_o,
  output logic [CW-1:0]                err_cnt_o
);

  apb_cfg_seq_state_e state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               abort_q, abort_d;
  logic               err_q, err_d;
  logic [IW-1:0]      err_idx_q, err_idx_d;
  logic [CW-1:0]      err_cnt_q, err_cnt_d;
  dhs_apb_req_t       req_q, req_d;
  logic               busy_q, busy_d;
  logic               rec_err, advance, abort_now, in_busy, in_setup, in_access, tmo_exp;
  logic               verify_cur;

`ifdef APB_CFG_SEQ_VERIFY_EN
  assign verify_cur = cfg_verify_i[idx_q];
`else
  logic unused_rd;
  assign unused_rd  = ^{cfg_verify_i, apb_resp_i.prdata};
  assign verify_cur = 1'b0;
`endif

  assign in_setup  = (state_q == ST_W_SETUP)  || (state_q == ST_R_SETUP);
  assign in_access = (state_q == ST_W_ACCESS) || (state_q == ST_R_ACCESS);
  assign in_busy   = in_setup || in_access;
  // A pulse arriving this very cycle counts as pending alongside a latched one.
  assign abort_now = abort_q || abort_i;

  apb_cfg_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk_i),
    .rst_n    (arst_ni),
    .load     (in_setup),
    .count_en (in_access),
    .expired  (tmo_exp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    abort_d   = abort_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    err_cnt_d = err_cnt_q;
    rec_err   = 1'b0;
    advance   = 1'b0;
    req_d     = '0;
    busy_d    = 1'b0;

    if (in_busy && abort_i) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d   = ST_W_SETUP;
          idx_d     = '0;
          abort_d   = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          err_cnt_d = '0;
        end
      end
      ST_W_SETUP: state_d = ST_W_ACCESS;
      ST_W_ACCESS: begin
        if (apb_resp_i.pready) begin
          if (apb_resp_i.pslverr) begin
            rec_err = 1'b1;
            advance = 1'b1;
          end else if (verify_cur && !abort_now) begin
            state_d = ST_R_SETUP;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_exp) begin
          rec_err = 1'b1;
          state_d = ST_DONE;
        end
      end
`ifdef APB_CFG_SEQ_VERIFY_EN
      ST_R_SETUP: state_d = ST_R_ACCESS;
      ST_R_ACCESS: begin
        if (apb_resp_i.pready) begin
          rec_err = apb_resp_i.pslverr || (apb_resp_i.prdata != cfg_data_i[idx_q]);
          advance = 1'b1;
        end else if (tmo_exp) begin
          rec_err = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if ((idx_q == IW'(NUM_ENTRIES - 1)) || abort_now) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_W_SETUP;
      end
    end

    // Each entry completes at most one failing transfer, so one increment per entry.
    if (rec_err) begin
      if (!err_q) err_idx_d = idx_q;
      err_d = 1'b1;
      if (err_cnt_q != CW'(NUM_ENTRIES)) err_cnt_d = err_cnt_q + 1'b1;
    end

    // Outputs are registered from the next state so the pins never glitch.
    case (state_d)
      ST_W_SETUP, ST_W_ACCESS: begin
        req_d.psel    = 1'b1;
        req_d.penable = (state_d == ST_W_ACCESS);
        req_d.pwrite  = 1'b1;
        req_d.paddr   = cfg_addr_i[idx_d];
        req_d.pwdata  = cfg_data_i[idx_d];
        req_d.pstrb   = '1;
        busy_d        = 1'b1;
      end
      ST_R_SETUP, ST_R_ACCESS: begin
        req_d.psel    = 1'b1;
        req_d.penable = (state_d == ST_R_ACCESS);
        req_d.paddr   = cfg_addr_i[idx_d];
        busy_d        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      err_cnt_q <= '0;
      req_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      err_cnt_q <= err_cnt_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
    end
  end

  assign apb_req_o = req_q;
  assign busy_o    = busy_q;
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_apb_cfg_sequencer.sv
// Bench for apb_cfg_sequencer: behavioural APB slave (memory, random wait states,
// error/corruption/hang injection) plus a table-walk reference model of the
// expected transfer list, error outcome and completion cycle.
module tb_apb_cfg_sequencer;
  import dual_helix_pkg::*;

  localparam int N = 4;
  localparam int T = 8;
`ifdef APB_CFG_SEQ_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic start = 1'b0;
  logic abort_man = 1'b0;
  logic abort_auto = 1'b0;
  logic abort_in;
  dhs_addr_t [N-1:0] cfg_addr;
  dhs_data_t [N-1:0] cfg_data;
  logic [N-1:0]      cfg_ver;
  dhs_apb_req_t      req;
  dhs_apb_resp_t     resp;
  logic              busy, done, err;
  logic [1:0]        err_idx;
  logic [2:0]        err_cnt;

  assign abort_in = abort_man | abort_auto;

  always #5 clk = ~clk;

  apb_cfg_sequencer #(.NUM_ENTRIES(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .arst_ni(arst_n), .start_i(start), .abort_i(abort_in),
    .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_verify_i(cfg_ver),
    .apb_req_o(req), .apb_resp_i(resp), .busy_o(busy), .done_o(done),
    .err_o(err), .err_idx_o(err_idx), .err_cnt_o(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
  } xfer_t;

  xfer_t       log_q[$];
  logic [31:0] mem [logic [31:0]];
  int          max_wait = 0;
  int          err_entry = -1, corrupt_entry = -1, hang_entry = -1, abort_entry = -1;
  logic [31:0] corrupt_mask = 32'h1;
  int          wcnt = 0, wused = 0;

  function automatic bit hits(int e, logic [31:0] a);
    if (e < 0 || e >= N) return 1'b0;
    return cfg_addr[e] == a;
  endfunction

  always @(negedge clk) begin
    resp = '0;
    abort_auto = 1'b0;
    if (req.psel && !req.penable) begin
      wused = int'($urandom_range(max_wait, 0));
      wcnt  = wused;
      if (req.pwrite && hits(abort_entry, req.paddr)) abort_auto = 1'b1;
    end else if (req.psel && req.penable) begin
      if (req.pwrite && hits(hang_entry, req.paddr)) begin
        resp.pready = 1'b0;
      end else if (wcnt > 0) begin
        wcnt--;
      end else begin
        resp.pready = 1'b1;
        if (req.pwrite) begin
          resp.pslverr = hits(err_entry, req.paddr);
          if (!resp.pslverr) mem[req.paddr] = req.pwdata;
        end else begin
          resp.prdata = (mem.exists(req.paddr) ? mem[req.paddr] : 32'h0) ^
                        (hits(corrupt_entry, req.paddr) ? corrupt_mask : 32'h0);
        end
        log_q.push_back('{req.pwrite, req.paddr, req.pwdata, req.pstrb, wused});
      end
    end
  end

  // ---------------- reference model ----------------
  xfer_t exp_q[$];
  bit    e_err, e_hang;
  int    e_idx, e_cnt;

  function automatic void rec(int i);
    if (e_cnt == 0) e_idx = i;
    e_cnt++;
    e_err = 1'b1;
  endfunction

  function automatic void model();
    exp_q.delete();
    e_err = 0; e_hang = 0; e_idx = 0; e_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (i == hang_entry) begin rec(i); e_hang = 1; break; end
      exp_q.push_back('{1'b1, cfg_addr[i], cfg_data[i], 4'hf, 0});
      if (i == err_entry) rec(i);
      else if (VEN && cfg_ver[i] && i != abort_entry) begin
        exp_q.push_back('{1'b0, cfg_addr[i], 32'h0, 4'h0, 0});
        if (i == corrupt_entry) rec(i);
      end
      if (i == abort_entry) break;
    end
  endfunction

  task automatic clear_inj();
    err_entry = -1; corrupt_entry = -1; hang_entry = -1; abort_entry = -1;
  endtask

  task automatic run_case(input string nm, input bit extra_start, output int k);
    int  exp_cyc;
    bit  busy_ok;
    model();
    log_q.delete();
    mem.delete();
    busy_ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; k = 1;
    chk({nm, "_busy_c1"}, busy, 1);
    chk({nm, "_ctl_c1"}, {req.psel, req.penable, req.pwrite}, 3'b101);
    chk({nm, "_addr_c1"}, req.paddr, cfg_addr[0]);
    while (!done && k < 3000) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk); k++;
      start = extra_start && (k == 3);
    end
    start = 1'b0;
    exp_cyc = 1 + (e_hang ? 1 + T : 0);
    foreach (log_q[j]) exp_cyc += 2 + log_q[j].waits;
    chk({nm, "_done_cycle"}, k, exp_cyc);
    chk({nm, "_busy_held"}, busy_ok, 1);
    chk({nm, "_req_idle_at_done"}, req, '0);
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_err"}, err, e_err);
    chk({nm, "_err_idx"}, err_idx, e_idx);
    chk({nm, "_err_cnt"}, err_cnt, e_cnt);
    chk({nm, "_n_xfers"}, log_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      chk($sformatf("%s_x%0d_wr", nm, j), log_q[j].wr, exp_q[j].wr);
      chk($sformatf("%s_x%0d_addr", nm, j), log_q[j].addr, exp_q[j].addr);
      chk($sformatf("%s_x%0d_wdata", nm, j), log_q[j].wdata, exp_q[j].wdata);
      chk($sformatf("%s_x%0d_strb", nm, j), log_q[j].strb, exp_q[j].strb);
    end
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  task automatic rand_table();
    logic [31:0] base;
    base = $urandom & 32'hFFFF_FF00;
    for (int i = 0; i < N; i++) begin
      cfg_addr[i] = base + 32'(i * 4);
      cfg_data[i] = $urandom;
      cfg_ver[i]  = 1'($urandom_range(1, 0));
    end
  endtask

  function automatic int pick(int range);
    int v;
    v = int'($urandom_range(range - 1, 0));
    return (v < N) ? v : -1;
  endfunction

  initial begin
    int  k;
    int  cnt;
    bit  saw;

    cfg_addr = '0; cfg_data = '0; cfg_ver = '0;
    #1;
    chk("rst_req", req, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err, err_idx, err_cnt}, 0);
    @(negedge clk); arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write-only, zero wait: UART programming sequence.
    cfg_addr[0] = UART_BASE;          cfg_data[0] = 32'h1;
    cfg_addr[1] = UART_BASE + 32'h4;  cfg_data[1] = 32'h9;
    cfg_addr[2] = UART_BASE + 32'h14; cfg_data[2] = 32'hab;
    cfg_addr[3] = UART_BASE + 32'h8;  cfg_data[3] = 32'h3;
    cfg_ver = '0; clear_inj(); max_wait = 0;
    run_case("wo", 1'b0, k);
    chk("wo_fixed_cycle", k, 2 * N + 1);

    // Abort pulse in IDLE must not be remembered.
    @(negedge clk); abort_man = 1'b1;
    @(negedge clk); abort_man = 1'b0;

    // Verify pass on RAM, all entries verified, zero wait.
    cfg_addr[0] = RAM_BASE; cfg_data[0] = 32'hDEADBEEF;
    cfg_ver = '1;
    run_case("vpass", 1'b0, k);
    chk("vpass_fixed_cycle", k, VEN ? 4 * N + 1 : 2 * N + 1);

    // Readback mismatch on entry 0, start re-pulsed while busy.
    corrupt_entry = 0; corrupt_mask = 32'h1;
    run_case("vmis", 1'b1, k);

    // Slave error on entry 2's write.
    clear_inj(); err_entry = 2; max_wait = 2;
    run_case("slverr", 1'b0, k);

    // Timeout on entry 1.
    clear_inj(); hang_entry = 1; max_wait = 1;
    run_case("tmo", 1'b0, k);

    // Abort during entry 0's write setup.
    clear_inj(); abort_entry = 0; max_wait = 0;
    run_case("abort", 1'b0, k);

    // start and abort together in IDLE: nothing happens.
    clear_inj(); log_q.delete();
    @(negedge clk); start = 1'b1; abort_man = 1'b1;
    @(negedge clk); start = 1'b0; abort_man = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      if (req.psel || busy) saw = 1'b1;
      @(negedge clk);
    end
    chk("sa_no_activity", saw, 0);
    chk("sa_no_xfers", log_q.size(), 0);

    // Reset mid W_ACCESS of entry 1, after entry 0 logged a slave error.
    clear_inj(); err_entry = 0; max_wait = 3; cfg_ver = '0; log_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!(req.psel && req.penable && req.paddr == cfg_addr[1]) && cnt < 200) begin
      @(negedge clk); cnt++;
    end
    chk("rr_reached", cnt < 200, 1);
    chk("rr_pre_err", {err, err_cnt}, {1'b1, 3'd1});
    arst_n = 1'b0;
    #1;
    chk("rr_req", req, '0);
    chk("rr_busy_done", {busy, done}, 0);
    chk("rr_err", {err, err_idx, err_cnt}, 0);
    @(negedge clk); arst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_idle_after", {busy, req.psel}, 0);

    // Randomized tables, waits and fault injection.
    for (int it = 0; it < 10; it++) begin
      rand_table();
      max_wait      = int'($urandom_range(3, 0));
      err_entry     = pick(2 * N);
      corrupt_entry = pick(2 * N);
      hang_entry    = pick(3 * N);
      abort_entry   = pick(3 * N);
      corrupt_mask  = $urandom | 32'h1;
      run_case($sformatf("rnd%0d", it), it[0], k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
